mem_bus_router: RTL and testbench

- Memory-side controller between the processor's request/response interface and the system's memory resources.
- Accepts one 65-bit processor request at a time and decodes its address to one of four targets: boot ROM, data RAM, MMIO or unmapped.
- Sequences a 1-cycle-latency synchronous word memory or a variable-latency MMIO handshake, then returns exactly one 32-bit response per request.
- Replaces ad-hoc testbench address decoding; sits directly on the processor's obtain_rq/send_rs ports.

---
 rtl/mem_bus_router.sv | 197 +++++++++++++++++++
 tb/tb_mem_bus_router.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_router.sv
// mem_bus_router
// Memory-side controller that sits on the processor's obtain_rq/send_rs
// ports. Each 65-bit request is decoded to boot ROM, data RAM, MMIO or
// unmapped space, the matching access is sequenced, and exactly one 32-bit
// response is returned per request. Only one request is outstanding at a time.
//
// Ports:
//   CLK, RST_N         clock (rising edge), asynchronous active-low reset
//   cpu_rq_rdy/cpu_rq  request pending / request {addr[64:33], iswrite[32], wdata[31:0]}
//   cpu_rq_en          dequeue the pending request this cycle
//   cpu_rs_rdy         processor can accept a response
//   cpu_rs_en/cpu_rs   response enqueue strobe / response data
//   mem_*              1-cycle-latency synchronous word memory (64 words)
//   mmio_*             variable-latency MMIO request/ack handshake
//   err_count          saturating count of error responses
//   dbg_state          current FSM state (IDLE=0, MEM=1, MEM_CAP=2, MMIO_WAIT=3, RESP=4)
//
// Handshakes: a request moves on an edge where cpu_rq_en=1, which is only
// raised in IDLE while cpu_rq_rdy=1; a response moves on an edge where
// cpu_rs_en=1, which is only raised in RESP while cpu_rs_rdy=1. In both cases
// the strobe is the transfer; nothing is implied by rdy alone.
module mem_bus_router #(
  parameter int          MMIO_TIMEOUT = 16,
  parameter logic [31:0] ERR_RESP     = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cpu_rq_rdy,
  input  logic [64:0] cpu_rq,
  output logic        cpu_rq_en,
  input  logic        cpu_rs_rdy,
  output logic        cpu_rs_en,
  output logic [31:0] cpu_rs,
  output logic        mem_en,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [8:0]  mmio_addr,
  output logic [31:0] mmio_wdata,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_rdata,
  output logic [7:0]  err_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM       = 3'd1,
    MEM_CAP   = 3'd2,
    MMIO_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam int TW = (MMIO_TIMEOUT > 1) ? $clog2(MMIO_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(MMIO_TIMEOUT - 1);

  state_t         state;
  logic           req_we;
  logic [31:0]    resp_q;
  logic           mem_en_q;
  logic           mem_we_q;
  logic [5:0]     mem_addr_q;
  logic [31:0]    mem_wdata_q;
  logic           mmio_req_q;
  logic           mmio_we_q;
  logic [8:0]     mmio_addr_q;
  logic [31:0]    mmio_wdata_q;
  logic [TW-1:0]  wait_cnt;
  logic [7:0]     err_cnt;

  // Request fields and address decode, looked at only on the accept edge.
  logic [31:0] rq_addr;
  logic        rq_we;
  logic [31:0] rq_wdata;
  logic        is_rom;
  logic        is_ram;
  logic        is_mmio;
  logic [7:0]  err_next;

  assign rq_addr  = cpu_rq[64:33];
  assign rq_we    = cpu_rq[32];
  assign rq_wdata = cpu_rq[31:0];

  // addr[1:0] does not change which region a word falls in, so the
  // full-address compares below are already word-aligned.
  assign is_rom  = (rq_addr < 32'h0000_0080);
  assign is_ram  = (rq_addr >= 32'h0000_0080) && (rq_addr < 32'h0000_0100);
  assign is_mmio = (rq_addr[31:9] == 23'd1);

  assign err_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      req_we       <= 1'b0;
      resp_q       <= 32'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 6'd0;
      mem_wdata_q  <= 32'd0;
      mmio_req_q   <= 1'b0;
      mmio_we_q    <= 1'b0;
      mmio_addr_q  <= 9'd0;
      mmio_wdata_q <= 32'd0;
      wait_cnt     <= '0;
      err_cnt      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_rq_rdy) begin
            req_we       <= rq_we;
            mem_addr_q   <= rq_addr[7:2];
            mem_wdata_q  <= rq_wdata;
            mmio_addr_q  <= rq_addr[8:0];
            mmio_we_q    <= rq_we;
            mmio_wdata_q <= rq_wdata;
            wait_cnt     <= '0;
            if ((is_rom && !rq_we) || is_ram) begin
              state    <= MEM;
              mem_en_q <= 1'b1;
              mem_we_q <= rq_we;
            end else if (is_mmio) begin
              state      <= MMIO_WAIT;
              mmio_req_q <= 1'b1;
            end else begin
              // ROM write or unmapped: answer straight away.
              state   <= RESP;
              resp_q  <= ERR_RESP;
              err_cnt <= err_next;
            end
          end
        end

        MEM: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (req_we) begin
            resp_q <= 32'd0;
            state  <= RESP;
          end else begin
            state <= MEM_CAP;
          end
        end

        MEM_CAP: begin
          // mem_rdata is valid the cycle after the read strobe.
          resp_q <= mem_rdata;
          state  <= RESP;
        end

        MMIO_WAIT: begin
          // Ack is checked first so an ack on the last wait cycle wins.
          if (mmio_ack) begin
            mmio_req_q <= 1'b0;
            resp_q     <= req_we ? 32'd0 : mmio_rdata;
            state      <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            mmio_req_q <= 1'b0;
            resp_q     <= ERR_RESP;
            err_cnt    <= err_next;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (cpu_rs_rdy) begin
            // Cleared on exit so cpu_rs reads 0 whenever no response is held.
            resp_q <= 32'd0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_rq_en  = (state == IDLE) & cpu_rq_rdy;
  assign cpu_rs_en  = (state == RESP) & cpu_rs_rdy;
  assign cpu_rs     = resp_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mmio_req   = mmio_req_q;
  assign mmio_we    = mmio_we_q;
  assign mmio_addr  = mmio_addr_q;
  assign mmio_wdata = mmio_wdata_q;
  assign err_count  = err_cnt;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_bus_router.sv
// Testbench for mem_bus_router: a 64-word memory model and an MMIO responder
// surround the DUT; expected responses come from a shadow copy of memory and
// fixed constants, queued on issue and popped when cpu_rs_en appears.
module tb_mem_bus_router;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cpu_rq_rdy = 1'b0;
  logic [64:0] cpu_rq = '0;
  logic        cpu_rq_en;
  logic        cpu_rs_rdy = 1'b1;
  logic        cpu_rs_en;
  logic [31:0] cpu_rs;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mmio_req;
  logic        mmio_we;
  logic [8:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_ack = 1'b0;
  logic [31:0] mmio_rdata = '0;
  logic [7:0]  err_count;
  logic [2:0]  dbg_state;

  mem_bus_router dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_rq_rdy(cpu_rq_rdy), .cpu_rq(cpu_rq), .cpu_rq_en(cpu_rq_en),
    .cpu_rs_rdy(cpu_rs_rdy), .cpu_rs_en(cpu_rs_en), .cpu_rs(cpu_rs),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [31:0] mem_model [64];
  logic        preloaded = 1'b0;

  always @(posedge CLK) begin
    if (!preloaded) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= (i == 3) ? 32'h00C00093 : 32'd0;
      mem_rdata <= 32'd0;
      preloaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_err  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] shadow [64];

  int          obs_lat;
  int          obs_mem_cnt;
  int          obs_mem_cyc;
  int          obs_mmio_cnt;
  logic [5:0]  obs_mem_addr;
  logic [8:0]  obs_mmio_addr;
  logic        obs_mmio_we;
  logic [31:0] obs_mmio_wdata;

  // ---------------- driver tasks ----------------
  // Present a request at a negedge and let it be accepted on the next posedge.
  // Returns at #1 after the accept edge, i.e. at the start of cycle 1.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    @(negedge CLK);
    cpu_rq     = {addr, we, wdata};
    cpu_rq_rdy = 1'b1;
    #1;
    n_checks++;
    if (cpu_rq_en !== 1'b1) begin
      n_fail++;
      $display("FAIL accept addr=%h: cpu_rq_en=%b expected 1", addr, cpu_rq_en);
    end
    @(posedge CLK);
    #1;
    cpu_rq_rdy = 1'b0;
  endtask

  // One complete transaction with cpu_rs_rdy held high. ack_cycle < 0 means
  // the MMIO responder never acks.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input int ack_cycle, input logic [31:0] ack_data,
                         input logic [31:0] exp_data, input int exp_lat, input string name);
    logic [31:0] exp;
    bit done;
    cpu_rs_rdy = 1'b1;
    issue(addr, we, wdata);
    exp_q.push_back(exp_data);
    done = 0;
    obs_lat = -1; obs_mem_cnt = 0; obs_mem_cyc = -1; obs_mmio_cnt = 0;
    for (int n = 1; n <= 40 && !done; n++) begin
      mmio_ack   = (mmio_req === 1'b1) && (n == ack_cycle);
      mmio_rdata = ack_data;
      if (mem_en === 1'b1) begin
        if (obs_mem_cyc < 0) obs_mem_cyc = n;
        obs_mem_cnt++;
        obs_mem_addr = mem_addr;
      end
      if (mmio_req === 1'b1) begin
        obs_mmio_cnt++;
        obs_mmio_addr  = mmio_addr;
        obs_mmio_we    = mmio_we;
        obs_mmio_wdata = mmio_wdata;
      end
      if (cpu_rs_en === 1'b1) begin
        obs_lat = n;
        done = 1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s resp: unexpected response %h", name, cpu_rs);
        end else begin
          exp = exp_q.pop_front();
          if (cpu_rs !== exp) begin
            n_fail++;
            $display("FAIL %s resp: got %h expected %h", name, cpu_rs, exp);
          end
        end
      end
      @(posedge CLK);
      #1;
    end
    mmio_ack = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: no cpu_rs_en within 40 cycles", name);
      if (exp_q.size() != 0) exp = exp_q.pop_front();
    end else if (obs_lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, obs_lat, exp_lat);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({cpu_rq_en, cpu_rs_en, mem_en, mem_we, mmio_req, mmio_we} !== 6'b0 ||
        cpu_rs !== 32'd0 || err_count !== 8'd0 || dbg_state !== 3'd0 ||
        mem_addr !== 6'd0 || mmio_addr !== 9'd0 || mem_wdata !== 32'd0 || mmio_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset outputs: rs=%h err=%h st=%0d mem_en=%b mmio_req=%b expected all 0",
               cpu_rs, err_count, dbg_state, mem_en, mmio_req);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_rom_read();
    run_txn(32'h0000_000C, 1'b0, 32'd0, -1, 32'd0, 32'h00C00093, 3, "rom_read");
    n_checks++;
    if (obs_mem_cnt != 1 || obs_mem_cyc != 1 || obs_mem_addr !== 6'd3) begin
      n_fail++;
      $display("FAIL rom_read mem: cnt=%0d cyc=%0d addr=%0d expected 1/1/3", obs_mem_cnt, obs_mem_cyc, obs_mem_addr);
    end
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rom_read err_count: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_ram_write_read();
    run_txn(32'h0000_0084, 1'b1, 32'hCAFEF00D, -1, 32'd0, 32'd0, 2, "ram_write");
    shadow[33] = 32'hCAFEF00D;
    n_checks++;
    if (obs_mem_cnt != 1 || obs_mem_addr !== 6'd33 || mem_model[33] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL ram_write mem: cnt=%0d addr=%0d word=%h expected 1/33/cafef00d",
               obs_mem_cnt, obs_mem_addr, mem_model[33]);
    end
    run_txn(32'h0000_0084, 1'b0, 32'd0, -1, 32'd0, shadow[33], 3, "ram_read");
    // Low address bits are ignored: 0x86 hits the same word.
    run_txn(32'h0000_0086, 1'b0, 32'd0, -1, 32'd0, shadow[33], 3, "ram_read_unaligned");
    // Top ROM word is readable.
    run_txn(32'h0000_007C, 1'b0, 32'd0, -1, 32'd0, shadow[31], 3, "rom_top_read");
  endtask

  task automatic test_errors();
    run_txn(32'h0000_0010, 1'b1, 32'h1111_2222, -1, 32'd0, 32'hDEADBEEF, 1, "rom_write");
    exp_err++;
    n_checks++;
    if (obs_mem_cnt != 0 || obs_mmio_cnt != 0) begin
      n_fail++;
      $display("FAIL rom_write side effects: mem_en cycles=%0d mmio_req cycles=%0d expected 0/0", obs_mem_cnt, obs_mmio_cnt);
    end
    run_txn(32'h0000_1000, 1'b0, 32'd0, -1, 32'd0, 32'hDEADBEEF, 1, "unmapped_1000");
    exp_err++;
    n_checks++;
    if (obs_mem_cnt != 0 || obs_mmio_cnt != 0 || err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL unmapped_1000: mem=%0d mmio=%0d err_count=%0d expected 0/0/%0d",
               obs_mem_cnt, obs_mmio_cnt, err_count, exp_err);
    end
    // Region boundaries just past RAM and just past MMIO.
    run_txn(32'h0000_0100, 1'b0, 32'd0, -1, 32'd0, 32'hDEADBEEF, 1, "unmapped_100");
    exp_err++;
    run_txn(32'h0000_0400, 1'b1, 32'd5, -1, 32'd0, 32'hDEADBEEF, 1, "unmapped_400");
    exp_err++;
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL errors err_count: got %0d expected %0d", err_count, exp_err);
    end
  endtask

  task automatic test_mmio();
    run_txn(32'h0000_0204, 1'b0, 32'd0, 5, 32'h12345678, 32'h12345678, 6, "mmio_read");
    n_checks++;
    if (obs_mmio_cnt != 5 || obs_mmio_addr !== 9'h004 || obs_mmio_we !== 1'b0) begin
      n_fail++;
      $display("FAIL mmio_read req: cycles=%0d addr=%h we=%b expected 5/004/0", obs_mmio_cnt, obs_mmio_addr, obs_mmio_we);
    end
    run_txn(32'h0000_03FC, 1'b1, 32'hA5A5_0F0F, 1, 32'hFFFF_FFFF, 32'd0, 2, "mmio_write");
    n_checks++;
    if (obs_mmio_cnt != 1 || obs_mmio_addr !== 9'h1FC || obs_mmio_we !== 1'b1 || obs_mmio_wdata !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("FAIL mmio_write req: cycles=%0d addr=%h we=%b wdata=%h expected 1/1fc/1/a5a50f0f",
               obs_mmio_cnt, obs_mmio_addr, obs_mmio_we, obs_mmio_wdata);
    end
    // Ack on the last wait cycle is a success, not a timeout.
    run_txn(32'h0000_0208, 1'b0, 32'd0, 16, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 17, "mmio_ack_last");
    n_checks++;
    if (obs_mmio_cnt != 16 || err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL mmio_ack_last: req cycles=%0d err_count=%0d expected 16/%0d", obs_mmio_cnt, err_count, exp_err);
    end
  endtask

  task automatic test_timeout_hold();
    logic [31:0] exp;
    int cnt;
    cpu_rs_rdy = 1'b0;
    issue(32'h0000_0240, 1'b0, 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    exp_err++;
    cnt = 0;
    for (int n = 1; n <= 16; n++) begin
      if (mmio_req === 1'b1) cnt++;
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (cnt != 16 || mmio_req !== 1'b0 || cpu_rs !== 32'hDEADBEEF || cpu_rs_en !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: req cycles=%0d req_now=%b rs=%h rs_en=%b expected 16/0/deadbeef/0",
               cnt, mmio_req, cpu_rs, cpu_rs_en);
    end
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL timeout err_count: got %0d expected %0d", err_count, exp_err);
    end
    // Backpressure: response held, no new request taken.
    cpu_rq     = {32'h0000_0084, 1'b0, 32'd0};
    cpu_rq_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (cpu_rs !== 32'hDEADBEEF || cpu_rq_en !== 1'b0 || cpu_rs_en !== 1'b0) begin
        n_fail++;
        $display("FAIL hold cycle %0d: rs=%h rq_en=%b rs_en=%b expected deadbeef/0/0", n, cpu_rs, cpu_rq_en, cpu_rs_en);
      end
      @(posedge CLK);
      #1;
    end
    cpu_rq_rdy = 1'b0;
    cpu_rs_rdy = 1'b1;
    #1;
    n_checks++;
    exp = exp_q.pop_front();
    if (cpu_rs_en !== 1'b1 || cpu_rs !== exp) begin
      n_fail++;
      $display("FAIL hold release: rs_en=%b rs=%h expected 1/%h", cpu_rs_en, cpu_rs, exp);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (dbg_state !== 3'd0 || cpu_rs !== 32'd0) begin
      n_fail++;
      $display("FAIL hold return: state=%0d rs=%h expected 0/0", dbg_state, cpu_rs);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    logic we;
    logic [31:0] d;
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(32, 63);
      we  = 1'($urandom_range(0, 1));
      d   = $urandom;
      if (we) begin
        run_txn(32'(idx * 4), 1'b1, d, -1, 32'd0, 32'd0, 2, "b2b_write");
        shadow[idx] = d;
      end else begin
        run_txn(32'(idx * 4), 1'b0, 32'd0, -1, 32'd0, shadow[idx], 3, "b2b_read");
      end
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) begin
      run_txn(32'h0001_0000 + 32'(i * 4), 1'b0, 32'd0, -1, 32'd0, 32'hDEADBEEF, 1, "sat");
      if (exp_err < 255) exp_err++;
    end
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d expected 255", err_count);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    cpu_rs_rdy = 1'b1;
    issue(32'h0000_0200, 1'b0, 32'd0);
    repeat (3) @(posedge CLK);
    #2;
    n_checks++;
    if (mmio_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid setup: mmio_req=%b expected 1", mmio_req);
    end
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (mmio_req !== 1'b0 || cpu_rs_en !== 1'b0 || mem_en !== 1'b0 || cpu_rs !== 32'd0 ||
        err_count !== 8'd0 || dbg_state !== 3'd0 || mmio_addr !== 9'd0 || cpu_rq_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: req=%b rs_en=%b rs=%h err=%0d st=%0d expected all 0",
               mmio_req, cpu_rs_en, cpu_rs, err_count, dbg_state);
    end
    exp_err = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge CLK);
      #1;
      if (cpu_rs_en === 1'b1 || mmio_req === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid abandoned: %0d cycles with response or request activity expected 0", seen);
    end
    run_txn(32'h0000_000C, 1'b0, 32'd0, -1, 32'd0, shadow[3], 3, "after_reset_read");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 32'd0;
    shadow[3] = 32'h00C00093;
    test_reset();
    test_rom_read();
    test_ram_write_read();
    test_errors();
    test_mmio();
    test_timeout_hold();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
